// File: rtl/button_seq_checker.sv
// Button-sequence checker: captures a SEQ_LEN-step challenge from the random
// code stream, then checks alternating player presses against it step by step.
module button_seq_checker #(
   parameter int SEQ_LEN        = 8,
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int CNT_W          = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] rand_code,
   input  logic [5:0] btn_p1,
   input  logic [5:0] btn_p2,
   output logic       busy,
   output logic       armed,
   output logic [3:0] cur_code,
   output logic       cur_player,
   output logic [3:0] step_idx,
   output logic       pass,
   output logic       fail,
   output logic [1:0] fail_reason
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RELEASE,
      S_ARMED
   } state_t;

   localparam logic [1:0]       REASON_BUTTON  = 2'd1;
   localparam logic [1:0]       REASON_PLAYER  = 2'd2;
   localparam logic [1:0]       REASON_TIMEOUT = 2'd3;
   localparam logic [3:0]       LAST_IDX       = 4'(SEQ_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_CNT       = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   logic [3:0]       r_buf [16];
   logic [3:0]       r_load_idx;
   logic [3:0]       r_step_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [5:0]       r_btn_p1_q;
   logic [5:0]       r_btn_p2_q;
   logic             r_busy;
   logic             r_armed;
   logic             r_pass;
   logic             r_fail;
   logic [1:0]       r_fail_reason;

   logic [5:0] w_press_p1;
   logic [5:0] w_press_p2;
   logic [5:0] w_own;
   logic [5:0] w_other;
   logic [5:0] w_exp_onehot;
   logic [3:0] w_exp_code;
   logic       w_timeout;
   logic       w_showing;

   assign w_press_p1   = btn_p1 & ~r_btn_p1_q;
   assign w_press_p2   = btn_p2 & ~r_btn_p2_q;
   // Odd steps belong to player 2, so step_idx[0] selects whose edges count.
   assign w_own        = r_step_idx[0] ? w_press_p2 : w_press_p1;
   assign w_other      = r_step_idx[0] ? w_press_p1 : w_press_p2;
   assign w_exp_code   = r_buf[r_step_idx];
   assign w_exp_onehot = 6'b000001 << w_exp_code;
   assign w_timeout    = (r_cnt == LAST_CNT);
   assign w_showing    = (r_state == S_RELEASE) || (r_state == S_ARMED);

   assign busy        = r_busy;
   assign armed       = r_armed;
   assign cur_code    = w_showing ? w_exp_code : 4'd0;
   assign cur_player  = r_step_idx[0];
   assign step_idx    = r_step_idx;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign fail_reason = r_fail_reason;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_load_idx    <= '0;
         r_step_idx    <= '0;
         r_cnt         <= '0;
         r_btn_p1_q    <= '0;
         r_btn_p2_q    <= '0;
         r_busy        <= 1'b0;
         r_armed       <= 1'b0;
         r_pass        <= 1'b0;
         r_fail        <= 1'b0;
         r_fail_reason <= 2'd0;
         // NOTE: the challenge buffer is reset on purpose so no stale codes survive an abort.
         for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      end else begin
         r_btn_p1_q <= btn_p1;
         r_btn_p2_q <= btn_p2;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               // A start landing on the pass/fail pulse cycle is dropped.
               if (start && !r_pass && !r_fail) begin
                  r_state       <= S_LOAD;
                  r_busy        <= 1'b1;
                  r_load_idx    <= '0;
                  r_step_idx    <= '0;
                  r_fail_reason <= 2'd0;
               end
            end

            S_LOAD: begin
               if (rand_code <= 4'd5) begin
                  r_buf[r_load_idx] <= rand_code;
                  r_load_idx        <= r_load_idx + 4'd1;
                  if (r_load_idx == LAST_IDX) r_state <= S_RELEASE;
               end
            end

            S_RELEASE: begin
               if (btn_p1 == 6'd0 && btn_p2 == 6'd0) begin
                  r_state <= S_ARMED;
                  r_armed <= 1'b1;
                  r_cnt   <= '0;
               end
            end

            S_ARMED: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_other != 6'd0) begin
                  r_state       <= S_IDLE;
                  r_busy        <= 1'b0;
                  r_armed       <= 1'b0;
                  r_fail        <= 1'b1;
                  r_fail_reason <= REASON_PLAYER;
               end else if (w_own != 6'd0) begin
                  if (w_own == w_exp_onehot) begin
                     r_armed <= 1'b0;
                     if (r_step_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b1;
                     end else begin
                        r_state    <= S_RELEASE;
                        r_step_idx <= r_step_idx + 4'd1;
                     end
                  end else begin
                     r_state       <= S_IDLE;
                     r_busy        <= 1'b0;
                     r_armed       <= 1'b0;
                     r_fail        <= 1'b1;
                     r_fail_reason <= REASON_BUTTON;
                  end
               end else if (w_timeout) begin
                  r_state       <= S_IDLE;
                  r_busy        <= 1'b0;
                  r_armed       <= 1'b0;
                  r_fail        <= 1'b1;
                  r_fail_reason <= REASON_TIMEOUT;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
